// File: rtl/dsp_out_pkg.sv
// Shared constants and arithmetic helpers for the DAC output stage.
// Widths here are the sample/gain/DAC formats the whole stage is built around.
package dsp_out_pkg;

    localparam int unsigned IW    = 16;
    localparam int unsigned GW    = 32;
    localparam int unsigned GFRAC = 30;
    localparam int unsigned OW    = 14;
    localparam int unsigned PW    = IW + GW + 1;
    localparam int unsigned SW    = PW - GFRAC + 1;

    localparam logic signed [OW-1:0] OUT_MAX  = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] OUT_MIN  = {1'b1, {(OW-1){1'b0}}};
    localparam logic        [OW-1:0] MIDSCALE = {1'b1, {(OW-1){1'b0}}};
    localparam logic signed [PW:0]   RND_HALF = (PW+1)'(1) << (GFRAC - 1);

    typedef struct packed {
        logic [OW-1:0] word;
        logic          sat;
    } sat_res_t;

    // Round half toward +inf, drop GFRAC fraction bits, clamp to the signed DAC range.
    function automatic sat_res_t sat_round(input logic signed [PW-1:0] prod);
        logic signed [PW:0]   biased;
        logic signed [SW-1:0] shifted;
        sat_res_t             res;
        biased   = (PW+1)'(prod) + RND_HALF;
        shifted  = biased[PW:GFRAC];
        res.word = shifted[OW-1:0];
        res.sat  = 1'b0;
        if (shifted > SW'(OUT_MAX)) begin
            res.word = OUT_MAX;
            res.sat  = 1'b1;
        end else if (shifted < SW'(OUT_MIN)) begin
            res.word = OUT_MIN;
            res.sat  = 1'b1;
        end
        return res;
    endfunction

    function automatic logic [OW-1:0] to_offset_binary(input logic [OW-1:0] w);
        return {~w[OW-1], w[OW-2:0]};
    endfunction

endpackage

// File: rtl/dac_output_stage_gain_ramp_chan.sv
// One channel: ramped gain, S1 multiply, S2 round/saturate and sticky saturation flag.
module gain_ramp_chan
    import dsp_out_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    input  logic                 s1_valid_i,
    input  logic                 gain_load_i,
    input  logic                 sat_clear_i,
    input  logic signed [IW-1:0] sample_i,
    input  logic        [GW-1:0] gain_target_i,
    input  logic        [GW-1:0] ramp_step_i,
    output logic        [OW-1:0] s2_word_o,
    output logic                 sat_o,
    output logic                 busy_c
);

    logic        [GW-1:0] gain_cur_q, gain_cur_d, gain_tgt_q, diff;
    logic signed [PW-1:0] prod_q, prod_d;
    logic        [OW-1:0] s2_word_q;
    logic                 sat_q;
    sat_res_t             rnd;

    // Step toward the target, landing exactly on it rather than overshooting.
    always_comb begin
        gain_cur_d = gain_cur_q;
        diff       = '0;
        if (ramp_step_i == '0) begin
            gain_cur_d = gain_tgt_q;
        end else if (gain_cur_q < gain_tgt_q) begin
            diff       = gain_tgt_q - gain_cur_q;
            gain_cur_d = (diff <= ramp_step_i) ? gain_tgt_q : gain_cur_q + ramp_step_i;
        end else if (gain_cur_q > gain_tgt_q) begin
            diff       = gain_cur_q - gain_tgt_q;
            gain_cur_d = (diff <= ramp_step_i) ? gain_tgt_q : gain_cur_q - ramp_step_i;
        end
    end

    // Sample uses the gain held in its own valid cycle, before the ramp update.
    assign prod_d = PW'(sample_i) * PW'({1'b0, gain_cur_q});
    assign rnd    = sat_round(prod_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            gain_cur_q <= '0;
            gain_tgt_q <= '0;
            prod_q     <= '0;
            s2_word_q  <= '0;
            sat_q      <= 1'b0;
        end else begin
            if (gain_load_i) gain_tgt_q <= gain_target_i;
            if (in_valid_i) begin
                gain_cur_q <= gain_cur_d;
                prod_q     <= prod_d;
            end
            if (s1_valid_i) s2_word_q <= rnd.word;
            if (s1_valid_i && rnd.sat) sat_q <= 1'b1;
            else if (sat_clear_i)      sat_q <= 1'b0;
        end
    end

    assign s2_word_o = s2_word_q;
    assign sat_o     = sat_q;
    assign busy_c    = (gain_cur_q != gain_tgt_q);

endmodule

// File: rtl/dac_output_stage.sv
// DAC output stage: per-channel ramped gain, round/saturate, any-channel-to-any-DAC
// routing and offset-binary conversion with a fixed three-cycle latency.
module dac_output_stage
    import dsp_out_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned NDAC = 2,
    parameter int unsigned SELW = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [NCH*IW-1:0]    in_data,
    input  logic [NCH*GW-1:0]    gain_target,
    input  logic                 gain_load,
    input  logic [GW-1:0]        ramp_step,
    input  logic [NDAC*SELW-1:0] dac_sel,
    input  logic                 sat_clear,
    output logic [NDAC*OW-1:0]   dac_data,
    output logic                 dac_valid,
    output logic [NCH-1:0]       sat_flags,
    output logic                 ramp_busy
);

    logic           v1_q, v2_q, dac_valid_q, ramp_busy_q;
    logic [NCH-1:0] busy_c, sat_vec;
    logic [OW-1:0]  s2_word  [NCH];
    logic [OW-1:0]  sel_word [NDAC];
    logic [OW-1:0]  dac_q    [NDAC];
    logic [OW-1:0]  dac_d    [NDAC];

    for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
        gain_ramp_chan u_chan (
            .clk           (sys_clk),
            .rst           (rst),
            .in_valid_i    (in_valid),
            .s1_valid_i    (v1_q),
            .gain_load_i   (gain_load),
            .sat_clear_i   (sat_clear),
            .sample_i      (in_data[ch*IW +: IW]),
            .gain_target_i (gain_target[ch*GW +: GW]),
            .ramp_step_i   (ramp_step),
            .s2_word_o     (s2_word[ch]),
            .sat_o         (sat_vec[ch]),
            .busy_c        (busy_c[ch])
        );
    end

    // S3 routing; an out-of-range select yields a zero sample (midscale word).
    always_comb begin
        for (int unsigned d = 0; d < NDAC; d++) begin
            sel_word[d] = '0;
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                if (32'(dac_sel[d*SELW +: SELW]) == ch) sel_word[d] = s2_word[ch];
            end
            dac_d[d] = v2_q ? to_offset_binary(sel_word[d]) : dac_q[d];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            dac_valid_q <= 1'b0;
            ramp_busy_q <= 1'b0;
            for (int unsigned d = 0; d < NDAC; d++) dac_q[d] <= MIDSCALE;
        end else begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            dac_valid_q <= v2_q;
            ramp_busy_q <= |busy_c;
            for (int unsigned d = 0; d < NDAC; d++) dac_q[d] <= dac_d[d];
        end
    end

    for (genvar d = 0; d < NDAC; d++) begin : g_out
        assign dac_data[d*OW +: OW] = dac_q[d];
    end

    assign dac_valid = dac_valid_q;
    assign sat_flags = sat_vec;
    assign ramp_busy = ramp_busy_q;

endmodule

// File: tb/tb_dac_output_stage.sv
// Directed bench for dac_output_stage: single-sample vector table plus
// streaming sequences for ramping, saturation-flag priority, routing and reset abort.
module tb_dac_output_stage;

    localparam int unsigned NCH  = 4;
    localparam int unsigned NDAC = 2;
    localparam int unsigned SELW = 2;
    localparam int unsigned IW   = 16;
    localparam int unsigned GW   = 32;
    localparam int unsigned OW   = 14;

    localparam logic [31:0] G_HALF = 32'h2000_0000;
    localparam logic [31:0] G_ONE  = 32'h4000_0000;
    localparam logic [31:0] G_TWO  = 32'h8000_0000;

    logic                 sys_clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [NCH*IW-1:0]    in_data;
    logic [NCH*GW-1:0]    gain_target;
    logic                 gain_load;
    logic [GW-1:0]        ramp_step;
    logic [NDAC*SELW-1:0] dac_sel;
    logic                 sat_clear;
    logic [NDAC*OW-1:0]   dac_data;
    logic                 dac_valid;
    logic [NCH-1:0]       sat_flags;
    logic                 ramp_busy;

    int n_vec = 0;
    int n_err = 0;

    dac_output_stage #(.NCH(NCH), .NDAC(NDAC), .SELW(SELW)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .gain_target (gain_target),
        .gain_load   (gain_load),
        .ramp_step   (ramp_step),
        .dac_sel     (dac_sel),
        .sat_clear   (sat_clear),
        .dac_data    (dac_data),
        .dac_valid   (dac_valid),
        .sat_flags   (sat_flags),
        .ramp_busy   (ramp_busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] gain;
        int          d0, d1, d2, d3;
        int          sel0, sel1;
        int          exp0, exp1;
        logic [3:0]  exp_sat;
    } vec_t;

    vec_t vecs[13];

    // Streaming stimulus/expectation arrays, indexed by sample (busy by negedge).
    int s_ch0[128], s_ch2[128], s_ch3[128];
    int e0[128], e1[128], e_busy[128];
    int sel_chg_at, sel_new0, sel_new1;

    function automatic int dac0();
        return int'(dac_data[OW-1:0]);
    endfunction

    function automatic int dac1();
        return int'(dac_data[2*OW-1:OW]);
    endfunction

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic set_sel(input int s0, input int s1);
        dac_sel = {2'(s1), 2'(s0)};
    endtask

    task automatic do_load(input logic [31:0] g0, input logic [31:0] g1,
                           input logic [31:0] g2, input logic [31:0] g3,
                           input logic [31:0] step);
        gain_target = {g3, g2, g1, g0};
        ramp_step   = step;
        gain_load   = 1'b1;
        tick();
        gain_load   = 1'b0;
    endtask

    task automatic pulse_valid(input int d0, input int d1, input int d2, input int d3);
        in_data  = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_stream();
        for (int i = 0; i < 128; i++) begin
            s_ch0[i] = 0; s_ch2[i] = 0; s_ch3[i] = 0;
            e0[i] = 8192; e1[i] = 8192; e_busy[i] = -1;
        end
        sel_chg_at = -1;
        sel_new0   = 0;
        sel_new1   = 0;
    endtask

    // Drive n back-to-back samples; sample j appears at the negedge three cycles later.
    task automatic run_stream(input string name, input int n);
        int j;
        for (int i = 0; i <= n + 2; i++) begin
            j = i - 3;
            if (j >= 0 && j < n) begin
                n_vec++;
                if (dac_valid !== 1'b1 || dac0() != e0[j] || dac1() != e1[j]) begin
                    n_err++;
                    $display("FAIL %s[%0d]: valid=%0b d0=%0d d1=%0d, want valid=1 d0=%0d d1=%0d",
                             name, j, dac_valid, dac0(), dac1(), e0[j], e1[j]);
                end
            end
            if (e_busy[i] >= 0) chk($sformatf("%s busy@%0d", name, i), int'(ramp_busy), e_busy[i]);
            if (i == sel_chg_at) set_sel(sel_new0, sel_new1);
            if (i < n) begin
                in_data  = {16'(s_ch3[i]), 16'(s_ch2[i]), 16'(0), 16'(s_ch0[i])};
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        vecs[0]  = '{G_ONE,   1000,      0,  0,  0, 0, 0,  9192,  9192, 4'b0000};
        vecs[1]  = '{G_ONE,  -1000,      0,  0,  0, 0, 0,  7192,  7192, 4'b0000};
        vecs[2]  = '{G_ONE,      0,  16000,  0,  0, 1, 0, 16383,  8192, 4'b0010};
        vecs[3]  = '{G_ONE,      0, -16000,  0,  0, 1, 0,     0,  8192, 4'b0010};
        vecs[4]  = '{G_HALF,     3,      0,  0,  0, 0, 0,  8194,  8194, 4'b0000};
        vecs[5]  = '{G_HALF,    -3,      0,  0,  0, 0, 0,  8191,  8191, 4'b0000};
        vecs[6]  = '{G_HALF,     1,      0,  0,  0, 0, 0,  8193,  8193, 4'b0000};
        vecs[7]  = '{G_HALF,    -1,      0,  0,  0, 0, 0,  8192,  8192, 4'b0000};
        vecs[8]  = '{G_ONE,      0,      0, 77, -5, 2, 3,  8269,  8187, 4'b0000};
        vecs[9]  = '{G_TWO,   4095,      0,  0,  0, 0, 0, 16382, 16382, 4'b0000};
        vecs[10] = '{G_TWO,   4096,      0,  0,  0, 0, 0, 16383, 16383, 4'b0001};
        vecs[11] = '{G_TWO,  -4096,      0,  0,  0, 0, 0,     0,     0, 4'b0000};
        vecs[12] = '{G_TWO,  -4097,      0,  0,  0, 0, 0,     0,     0, 4'b0001};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; gain_target = '0;
        gain_load = 1'b0; ramp_step = '0; dac_sel = '0; sat_clear = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset / idle state.
        chk("reset dac0", dac0(), 8192);
        chk("reset dac1", dac1(), 8192);
        chk("reset valid", int'(dac_valid), 0);
        chk("reset sat", int'(sat_flags), 0);
        chk("reset busy", int'(ramp_busy), 0);

        // Ramp 0 -> 1.0 in quarter steps; busy drops one cycle after arrival.
        set_sel(0, 0);
        do_load(G_ONE, 0, 0, 0, 32'h1000_0000);
        clear_stream();
        for (int i = 0; i < 5; i++) s_ch0[i] = 4096;
        e0[0] = 8192; e0[1] = 9216; e0[2] = 10240; e0[3] = 11264; e0[4] = 12288;
        for (int i = 0; i < 5; i++) e1[i] = e0[i];
        e_busy[1] = 1; e_busy[4] = 1; e_busy[5] = 0;
        run_stream("ramp_up", 5);

        // Step 0.75 clamps at 1.0 without overshoot.
        do_load(0, 0, 0, 0, 0);
        pulse_valid(0, 0, 0, 0);
        do_load(G_ONE, 0, 0, 0, 32'h3000_0000);
        clear_stream();
        for (int i = 0; i < 4; i++) s_ch0[i] = 4096;
        e0[0] = 8192; e0[1] = 11264; e0[2] = 12288; e0[3] = 12288;
        for (int i = 0; i < 4; i++) e1[i] = e0[i];
        run_stream("ramp_clamp", 4);

        // Retarget to 0 mid-ramp: ramps down from the present gain.
        do_load(0, 0, 0, 0, 0);
        pulse_valid(0, 0, 0, 0);
        do_load(G_ONE, 0, 0, 0, 32'h1000_0000);
        clear_stream();
        s_ch0[0] = 4096; s_ch0[1] = 4096;
        e0[0] = 8192; e0[1] = 9216; e1[0] = 8192; e1[1] = 9216;
        run_stream("ramp_pre", 2);
        do_load(0, 0, 0, 0, 32'h1000_0000);
        clear_stream();
        for (int i = 0; i < 4; i++) s_ch0[i] = 4096;
        e0[0] = 10240; e0[1] = 9216; e0[2] = 8192; e0[3] = 8192;
        for (int i = 0; i < 4; i++) e1[i] = e0[i];
        run_stream("ramp_down", 4);

        // Saturation set coinciding with sat_clear keeps the flag; clear alone drops it.
        do_load(G_ONE, G_ONE, G_ONE, G_ONE, 0);
        pulse_valid(0, 0, 0, 0);
        sat_clear = 1'b1; tick(); sat_clear = 1'b0;
        set_sel(1, 0);
        in_data  = {16'(0), 16'(0), 16'(16000), 16'(0)};
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        chk("sat set beats clear", int'(sat_flags), 2);
        repeat (2) tick();
        chk("sat word", dac0(), 16383);
        sat_clear = 1'b1; tick(); sat_clear = 1'b0;
        chk("sat clear alone", int'(sat_flags), 0);

        // Single-sample vector table.
        foreach (vecs[k]) begin
            sat_clear = 1'b1; tick(); sat_clear = 1'b0;
            do_load(vecs[k].gain, vecs[k].gain, vecs[k].gain, vecs[k].gain, 0);
            pulse_valid(0, 0, 0, 0);
            set_sel(vecs[k].sel0, vecs[k].sel1);
            pulse_valid(vecs[k].d0, vecs[k].d1, vecs[k].d2, vecs[k].d3);
            repeat (2) tick();
            chk($sformatf("vec%0d valid", k), int'(dac_valid), 1);
            chk($sformatf("vec%0d dac0", k), dac0(), vecs[k].exp0);
            chk($sformatf("vec%0d dac1", k), dac1(), vecs[k].exp1);
            chk($sformatf("vec%0d sat", k), int'(sat_flags), int'(vecs[k].exp_sat));
        end

        // Full-rate stream on ch2 with a select change partway through.
        do_load(G_ONE, G_ONE, G_ONE, G_ONE, 0);
        pulse_valid(0, 0, 0, 0);
        set_sel(2, 3);
        clear_stream();
        sel_chg_at = 50; sel_new0 = 0; sel_new1 = 3;
        for (int i = 0; i < 100; i++) begin
            s_ch0[i] = 500;
            s_ch2[i] = i;
            s_ch3[i] = -7;
            e0[i]    = (i >= 48) ? 8692 : 8192 + i;
            e1[i]    = 8185;
        end
        run_stream("stream", 100);

        // Reset in flight drops the pending sample.
        pulse_valid(1000, 0, 0, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 4; i++) begin
                if (dac_valid) seen++;
                tick();
            end
            chk("reset abort valids", seen, 0);
        end
        chk("reset abort dac0", dac0(), 8192);
        chk("reset abort busy", int'(ramp_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
